// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with start/stop checking feeding an 8-entry first-word-fall-through FIFO
module uart_rx_fifo #(
    parameter int bps   = 9600,
    parameter int CLK_F = 12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       empty,
    output logic       full,
    output logic [3:0] level,
    output logic       busy,
    output logic       frame_err,
    output logic       overflow
);
    localparam int DIV  = CLK_F / bps;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    mem_q [8];
    logic [7:0]    mem_d [8];
    logic [2:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [3:0]    level_q, level_d;
    logic          fe_q, fe_d, ov_q, ov_d;
    logic          rxs, tick, push, pop, wr;

    assign rxs  = sync_q[1];
    assign tick = cnt_q == '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        push    = 1'b0;
        fe_d    = 1'b0;
        sync_d  = {sync_q[0], rx};
        case (state_q)
            IDLE: if (!rxs) begin
                cnt_d   = CW'(HALF - 1);
                state_d = START;
            end
            START: if (!tick) cnt_d = cnt_q - 1'b1;
            else if (rxs) state_d = IDLE;
            else begin
                cnt_d   = CW'(DIV - 1);
                idx_d   = 3'd0;
                state_d = DATA;
            end
            DATA: if (!tick) cnt_d = cnt_q - 1'b1;
            else begin
                sh_d    = {rxs, sh_q[7:1]};
                cnt_d   = CW'(DIV - 1);
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (!tick) cnt_d = cnt_q - 1'b1;
            else begin
                push    = rxs;
                fe_d    = !rxs;
                state_d = rxs ? IDLE : RECOVER;
            end
            RECOVER: state_d = rxs ? IDLE : RECOVER;
            default: state_d = IDLE;
        endcase
    end

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands
    always_comb begin
        pop      = rd_en && level_q != 4'd0;
        wr       = push && (level_q != 4'd8 || pop);
        ov_d     = push && !wr;
        level_d  = level_q + 4'(wr) - 4'(pop);
        rd_ptr_d = pop ? rd_ptr_q + 3'd1 : rd_ptr_q;
        wr_ptr_d = wr ? wr_ptr_q + 3'd1 : wr_ptr_q;
        mem_d    = mem_q;
        if (wr) mem_d[wr_ptr_q] = sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
        end
    end

    assign empty     = level_q == 4'd0;
    assign full      = level_q == 4'd8;
    assign level     = level_q;
    assign data      = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign busy      = state_q != IDLE;
    assign frame_err = fe_q;
    assign overflow  = ov_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: bench for uart_rx_fifo comparing every cycle against a byte-queue model of received frames
module tb_uart_rx_fifo;
    localparam int DIV  = 16;
    localparam int HALF = 8;
    localparam int LAT  = 3 + HALF + 9 * DIV;

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0;
    logic [7:0] data;
    logic       empty, full, busy, frame_err, overflow;
    logic [3:0] level;

    uart_rx_fifo #(.bps(1), .CLK_F(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .data(data), .empty(empty),
        .full(full), .level(level), .busy(busy), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {int c; logic [7:0] b; logic s;} ev_t;
    ev_t        ev[$];
    logic [7:0] q[$];
    int         cyc = 0, start_cyc = 0, tests = 0, fails = 0, ov_cnt = 0, fe_cnt = 0;
    logic       rd_seen = 1'b0, rst_seen = 1'b0;
    bit         m_pop, m_full;
    logic       e_fe, e_ov;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_seen  <= rd_en;
        rst_seen <= rst;
    end

    always @(negedge clk) begin
        if (overflow) ov_cnt <= ov_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: each frame's stop sample lands LAT cycles after its rx falling edge
    initial forever begin
        @(negedge clk);
        e_fe = 1'b0;
        e_ov = 1'b0;
        if (rst_seen) q.delete();
        else begin
            m_pop  = rd_seen && q.size() > 0;
            m_full = q.size() == 8;
            if (m_pop) void'(q.pop_front());
            if (ev.size() > 0 && ev[0].c == cyc) begin
                if (!ev[0].s) e_fe = 1'b1;
                else if (!m_full || m_pop) q.push_back(ev[0].b);
                else e_ov = 1'b1;
                void'(ev.pop_front());
            end
        end
        chk("level", 32'(level), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == 8));
        chk("data", 32'(data), q.size() > 0 ? 32'(q[0]) : 32'h0);
        chk("frame_err", 32'(frame_err), 32'(e_fe));
        chk("overflow", 32'(overflow), 32'(e_ov));
    end

    task automatic send(input logic [7:0] b, input logic s);
        start_cyc = cyc;
        rx = 1'b0;
        ev.push_back('{start_cyc + LAT, b, s});
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = s;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic pop_exp(input logic [7:0] e);
        chk("pop_data", 32'(data), 32'(e));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pulses", 32'({frame_err, overflow}), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hA5, 1'b1);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_level", 32'(level), 32'h1);
        pop_exp(8'hA5);
        chk("a5_popped", 32'({empty, level}), 32'h10);

        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_idle", 32'(busy), 32'h0);
        chk("glitch_level", 32'(level), 32'h0);

        send(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        chk("recover_busy", 32'(busy), 32'h1);
        chk("fe_level", 32'(level), 32'h0);
        chk("fe_count", 32'(fe_cnt), 32'h1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("recover_exit", 32'(busy), 32'h0);
        send(8'h11, 1'b1);
        repeat (2) @(negedge clk);
        pop_exp(8'h11);

        for (int k = 1; k <= 9; k++) send(8'(k), 1'b1);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_level", 32'(level), 32'h8);
        chk("ov_count", 32'(ov_cnt), 32'h1);
        for (int k = 1; k <= 8; k++) pop_exp(8'(k));
        chk("drained", 32'(empty), 32'h1);

        send(8'h21, 1'b1);
        send(8'h22, 1'b1);
        send(8'h23, 1'b1);
        pop_exp(8'h21);
        pop_exp(8'h22);
        send(8'h24, 1'b1);
        pop_exp(8'h23);
        pop_exp(8'h24);

        for (int k = 0; k < 8; k++) send(8'h40 + 8'(k), 1'b1);
        chk("sim_full", 32'(full), 32'h1);
        fork
            send(8'h48, 1'b1);
            begin
                for (int k = 0; k < 400 && cyc != start_cyc + LAT - 1; k++) @(negedge clk);
                chk("pop_align", 32'(cyc), 32'(start_cyc + LAT - 1));
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        chk("sim_level", 32'(level), 32'h8);
        chk("sim_ov_count", 32'(ov_cnt), 32'h1);
        for (int k = 1; k <= 8; k++) pop_exp(8'h40 + 8'(k));
        chk("sim_drained", 32'(empty), 32'h1);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
